// File: rtl/hartslag_ctrl_pkg.sv
// hartslag_pkg: shared types and defaults for the heartbeat sequencer.
//   state_t  - FSM state encoding, visible on state_out
//   DEF_*    - default parameter values for hartslag_ctrl
//   log2_n   - exponent of a power-of-two averaging depth
package hartslag_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    LOST    = 2'd3
  } state_t;

  localparam int DEF_CNT_W   = 25;
  localparam int DEF_MIN_IVL = 2**20;
  localparam int DEF_MAX_IVL = 2**25 - 1;
  localparam int DEF_AVG_N   = 4;
  localparam int DEF_LEVEL_W = 4;

  function automatic int log2_n(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/hartslag_ctrl_beat_sync.sv
// beat_sync: brings the asynchronous heartbeat pulse into the clk domain
// and turns each rising edge into a single-cycle strobe.
//   clk, reset - system clock, async active-high reset
//   d_in       - raw asynchronous pulse
//   pulse_out  - registered one-cycle strobe, 3 clk after the d_in rise
module beat_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic pulse_out
);

  logic s1, s2, s3;

  // s1/s2 are the metastability pair; s3 holds the previous synchronised
  // level for edge detection. Registering the strobe keeps it glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      s1        <= d_in;
      s2        <= s1;
      s3        <= s2;
      pulse_out <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/hartslag_ctrl.sv
// hartslag_ctrl: heartbeat measurement sequencer for the rocking controller.
// Times beat-to-beat intervals, rejects glitches and signal loss, averages
// the last AVG_N intervals and publishes a quantised level.
//   clk, reset  - system clock, async active-high reset
//   enable      - measurement enable; low returns to IDLE
//   beat_in     - raw asynchronous heartbeat pulse
//   level_out   - averaged interval level (larger = slower heart)
//   level_valid - one-cycle strobe when level_out updates
//   state_out   - FSM state encoding
//   lost        - high while in LOST
import hartslag_pkg::*;

module hartslag_ctrl #(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MIN_IVL = DEF_MIN_IVL,
  parameter int MAX_IVL = DEF_MAX_IVL,
  parameter int AVG_N   = DEF_AVG_N,
  parameter int LEVEL_W = DEF_LEVEL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               beat_in,
  output logic [LEVEL_W-1:0] level_out,
  output logic               level_valid,
  output logic [1:0]         state_out,
  output logic               lost
);

  localparam int LOG_N  = log2_n(AVG_N);
  localparam int SUM_W  = CNT_W + LOG_N;
  localparam int FILL_W = LOG_N + 1;
  localparam logic [CNT_W-1:0]  MIN_C = CNT_W'(MIN_IVL);
  localparam logic [CNT_W-1:0]  MAX_C = CNT_W'(MAX_IVL);
  localparam logic [FILL_W-1:0] FULL  = FILL_W'(AVG_N);
  localparam logic [FILL_W-1:0] LAST  = FILL_W'(AVG_N - 1);

  state_t state, state_nx;
  logic beat;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic has_ref;
  logic [AVG_N-1:0][CNT_W-1:0] hist;  // [0] newest, [AVG_N-1] oldest
  logic [SUM_W-1:0] sum, sum_nx;
  logic [FILL_W-1:0] fill;
  logic ref_beat, accept, timeout, push, load, clr;

  beat_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .d_in      (beat_in),
    .pulse_out (beat)
  );

  // cnt saturates at MAX_C, so the upper acceptance bound always holds.
  assign ref_beat = beat & ~has_ref;
  assign accept   = beat & has_ref & (cnt >= MIN_C);
  assign timeout  = has_ref & ~beat & (cnt == MAX_C);
  assign push     = enable & accept & (state == ACQUIRE || state == TRACK);
  assign load     = enable & (state != IDLE) & (ref_beat | push);
  assign clr      = ~enable | (state == IDLE) | timeout;
  assign cnt_inc  = (cnt == MAX_C) ? cnt : cnt + CNT_W'(1);
  // History starts zeroed, so subtracting the oldest slot is correct
  // even before the window has filled.
  assign sum_nx   = sum + SUM_W'(cnt) - SUM_W'(hist[AVG_N-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!enable) state_nx = IDLE;
    else begin
      unique case (state)
        IDLE:    state_nx = ACQUIRE;
        ACQUIRE: if (push && fill == LAST) state_nx = TRACK;
                 else if (timeout)         state_nx = LOST;
        TRACK:   if (timeout)              state_nx = LOST;
        LOST:    if (beat)                 state_nx = ACQUIRE;
      endcase
    end
  end

  always_comb begin
    state_out = state;
    lost      = (state == LOST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      has_ref     <= 1'b0;
      hist        <= '0;
      sum         <= '0;
      fill        <= '0;
      level_out   <= '0;
      level_valid <= 1'b0;
    end else begin
      level_valid <= 1'b0;
      if (!enable || state == IDLE) cnt <= '0;
      else if (load)                cnt <= CNT_W'(1);
      else                          cnt <= cnt_inc;

      // level_out is deliberately untouched by clr: it holds across
      // disable and loss.
      if (clr) begin
        has_ref <= 1'b0;
        hist    <= '0;
        sum     <= '0;
        fill    <= '0;
      end else begin
        if (ref_beat) has_ref <= 1'b1;
        if (push) begin
          hist <= {hist[AVG_N-2:0], cnt};
          sum  <= sum_nx;
          if (fill != FULL) fill <= fill + FILL_W'(1);
          if (state == TRACK || fill == LAST) begin
            // (sum >> LOG_N)[CNT_W-1 -: LEVEL_W] is the top of sum_nx
            level_out   <= sum_nx[SUM_W-1 -: LEVEL_W];
            level_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule
